// File: rtl/predistort_taps_loader_pkg.sv
// Shared constants and types for the predistort coefficient loader.
package predistort_taps_loader_pkg;

    // Settings register offsets relative to SR_BASE.
    localparam logic [7:0] SrTap    = 8'd0;
    localparam logic [7:0] SrCommit = 8'd1;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StStream
    } state_e;

    // Number of taps held in the table for a given log2 depth.
    function automatic int unsigned tap_count(input int unsigned depth);
        return 32'd1 << depth;
    endfunction

endpackage

// File: rtl/taps_ram_1r1w.sv
// Simple dual-port tap table: one write port, one synchronous read port, no reset.
module taps_ram_1r1w #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [1 << DEPTH];

    // Write port and registered read; rdata holds while re is low.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/predistort_taps_loader.sv
// Collects taps from the settings bus and streams the table to predistort on commit.
module predistort_taps_loader
    import predistort_taps_loader_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 7,
    parameter logic [7:0]  SR_BASE = 8'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [WIDTH-1:0] taps_tdata,
    output logic             taps_tlast,
    output logic             taps_tvalid,
    input  logic             taps_tready,
    output logic             busy,
    output logic             write_err,
    output logic [15:0]      commit_count
);

    localparam int unsigned    Taps       = tap_count(DEPTH);
    localparam logic [DEPTH:0] TapsCnt    = (DEPTH + 1)'(Taps);
    localparam logic [DEPTH:0] RdStart    = (DEPTH + 1)'(2);
    localparam logic [DEPTH-1:0] LastIdx  = {DEPTH{1'b1}};
    localparam logic [7:0]     TapAddr    = SR_BASE + SrTap;
    localparam logic [7:0]     CommitAddr = SR_BASE + SrCommit;

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             valid_q, last_q;
    logic [WIDTH-1:0] data_q;
    logic [DEPTH-1:0] out_idx_q;
    logic [DEPTH-1:0] next_idx;
    logic [DEPTH:0]   rd_cnt_q;
    logic [15:0]      count_q;
    logic             err_q;

    logic             tap_wr, commit_hit, busy_int;
    logic             hs, last_hs, restart, rd_done;
    logic             re, ld_first, ld_next;
    logic [DEPTH-1:0] raddr;
    logic [WIDTH-1:0] rdata;
    logic             unused_data;

    assign tap_wr      = set_stb && (set_addr == TapAddr);
    assign commit_hit  = set_stb && (set_addr == CommitAddr);
    assign busy_int    = (state_q != StIdle) || pending_q;
    assign hs          = valid_q && taps_tready;
    assign last_hs     = (state_q == StStream) && hs && last_q;
    // A commit landing on the final handshake counts as pending so it is not lost.
    assign restart     = last_hs && (pending_q || commit_hit) && !clear;
    assign rd_done     = (rd_cnt_q == TapsCnt);
    assign next_idx    = out_idx_q + DEPTH'(1);
    assign unused_data = ^set_data;

    taps_ram_1r1w #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (tap_wr && !busy_int),
        .waddr(set_data[16 +: DEPTH]),
        .wdata(set_data[WIDTH-1:0]),
        .re   (re),
        .raddr(raddr),
        .rdata(rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (commit_hit) state_d = StPrime;
            StPrime:  state_d = StStream;
            StStream: if (last_hs) state_d = restart ? StPrime : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: RAM read issue and output-register load controls.
    always_comb begin
        re       = 1'b0;
        raddr    = rd_cnt_q[DEPTH-1:0];
        ld_first = 1'b0;
        ld_next  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (commit_hit) begin
                    re    = 1'b1;
                    raddr = '0;
                end
            end
            StPrime: begin
                ld_first = 1'b1;
                re       = 1'b1;
                raddr    = '0;
                raddr[0] = 1'b1;
            end
            StStream: begin
                // RAM output register is the skid: it only advances when a beat leaves.
                if (hs && !last_q) begin
                    ld_next = 1'b1;
                    re      = !rd_done;
                end
                if (restart) begin
                    re    = 1'b1;
                    raddr = '0;
                end
            end
            default: ;
        endcase
    end

    // Pending commit flag; clear has the final say.
    always_comb begin
        pending_d = pending_q;
        if (state_q != StIdle && commit_hit) pending_d = 1'b1;
        if (restart) pending_d = 1'b0;
        if (clear) pending_d = 1'b0;
    end

    // Output register, read counter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            out_idx_q <= '0;
            rd_cnt_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (ld_first) begin
                data_q    <= rdata;
                valid_q   <= 1'b1;
                last_q    <= 1'b0;
                out_idx_q <= '0;
                rd_cnt_q  <= RdStart;
            end else if (ld_next) begin
                data_q    <= rdata;
                last_q    <= (next_idx == LastIdx);
                out_idx_q <= next_idx;
                if (re) rd_cnt_q <= rd_cnt_q + (DEPTH + 1)'(1);
            end else if (last_hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
            if (last_hs) count_q <= count_q + 16'd1;
            if (clear) begin
                err_q <= 1'b0;
            end else if (tap_wr && busy_int) begin
                err_q <= 1'b1;
            end
        end
    end

    assign taps_tdata   = data_q;
    assign taps_tlast   = last_q;
    assign taps_tvalid  = valid_q;
    assign busy         = busy_int;
    assign write_err    = err_q;
    assign commit_count = count_q;

endmodule

// File: tb/tb_predistort_taps_loader.sv
// Bench for predistort_taps_loader: packet-level model plus directed scenarios.
module tb_predistort_taps_loader;

    localparam int         N    = 128;
    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] taps_tdata;
    logic        taps_tlast, taps_tvalid, taps_tready;
    logic        busy, write_err;
    logic [15:0] commit_count;

    predistort_taps_loader #(
        .WIDTH(16),
        .DEPTH(7),
        .SR_BASE(BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .set_stb     (set_stb),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .taps_tdata  (taps_tdata),
        .taps_tlast  (taps_tlast),
        .taps_tvalid (taps_tvalid),
        .taps_tready (taps_tready),
        .busy        (busy),
        .write_err   (write_err),
        .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tap table, queue of beats still owed, pending flag, status.
    typedef struct {
        logic [15:0] d;
        int          idx;
    } beat_t;

    logic [15:0] tab [N];
    beat_t       q [$];
    bit          m_pend = 0;
    bit          m_err  = 0;
    logic [15:0] m_cnt  = '0;

    logic [15:0] got [N];
    int          got_n = 0;
    int          cyc = 0, first_cyc = 0, last_cyc = 0;
    bit          chk_en = 0;
    bit          rnd_mode = 0;

    function automatic bit m_busy();
        return (q.size() != 0) || m_pend;
    endfunction

    task automatic push_packet();
        for (int i = 0; i < N; i++) q.push_back('{d: tab[i], idx: i});
    endtask

    always @(posedge clk) cyc++;

    initial begin
        taps_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            taps_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Every-cycle comparison against the model, then consume handshaken beats.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, m_busy()});
            check("write_err", {31'b0, write_err}, {31'b0, m_err});
            check("commit_count", {16'b0, commit_count}, {16'b0, m_cnt});
            if (taps_tvalid) begin
                if (q.size() == 0) begin
                    check("tvalid_unexpected", {31'b0, taps_tvalid}, 32'd0);
                end else begin
                    check("tdata", {16'b0, taps_tdata}, {16'b0, q[0].d});
                    check("tlast", {31'b0, taps_tlast}, {31'b0, q[0].idx == N - 1});
                    if (taps_tready) begin
                        beat_t e;
                        e = q.pop_front();
                        got[e.idx] = taps_tdata;
                        if (e.idx == 0) first_cyc = cyc;
                        got_n = e.idx + 1;
                        if (e.idx == N - 1) begin
                            last_cyc = cyc;
                            m_cnt = m_cnt + 16'd1;
                            if (m_pend) begin
                                m_pend = 0;
                                push_packet();
                            end
                        end
                    end
                end
            end else if (q.size() != 0 && q[0].idx != 0) begin
                check("tvalid_dropped", {31'b0, taps_tvalid}, 32'd1);
            end
        end
    end

    task automatic sb_write(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge clk);
        if (a == BASE) begin
            if (m_busy()) m_err = 1;
            else tab[d[22:16]] = d[15:0];
        end else if (a == BASE + 8'd1) begin
            if (m_busy()) m_pend = 1;
            else push_packet();
        end
        #1 set_stb = 1'b0;
    endtask

    task automatic commit();
        sb_write(BASE + 8'd1, 32'hFFFF_FFFF);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        m_pend = 0;
        m_err  = 0;
        #1 clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        q.delete();
        m_pend = 0;
        m_err  = 0;
        m_cnt  = '0;
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!m_busy() && !busy) done = 1;
        end
        if (!done) check("idle_timeout", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int k);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (got_n >= k) done = 1;
        end
        if (!done) check("beat_timeout", got_n, k);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1;
        @(negedge clk);
        check("rst_tvalid", {31'b0, taps_tvalid}, 32'd0);
        check("rst_tlast", {31'b0, taps_tlast}, 32'd0);
        check("rst_tdata", {16'b0, taps_tdata}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, write_err}, 32'd0);
        check("rst_count", {16'b0, commit_count}, 32'd0);
        @(posedge clk);
        #1;

        // Fill the table with 0x1000+i and stream it with tready held high.
        for (int i = 0; i < N; i++) sb_write(BASE, (i << 16) | (32'h1000 + i));
        commit();
        @(negedge clk);
        check("latency_n1", {31'b0, taps_tvalid}, 32'd0);
        @(negedge clk);
        check("latency_n2", {31'b0, taps_tvalid}, 32'd1);
        check("first_beat", {16'b0, taps_tdata}, 32'h1000);
        wait_idle();
        check("pkt_cycles", last_cyc - first_cyc, 32'd127);
        check("pkt1_beats", got_n, 32'd128);
        check("pkt1_last", {16'b0, got[127]}, 32'h107F);
        check("pkt1_count", {16'b0, commit_count}, 32'd1);

        // Random backpressure.
        rnd_mode = 1;
        commit();
        wait_idle();
        rnd_mode = 0;
        check("pkt2_mid", {16'b0, got[64]}, 32'h1040);
        check("pkt2_count", {16'b0, commit_count}, 32'd2);

        // Three commits mid-packet collapse into one more packet.
        commit();
        wait_beats(41);
        commit();
        commit();
        commit();
        wait_idle();
        check("pending_count", {16'b0, commit_count}, 32'd4);

        // Write while streaming is dropped and flagged.
        commit();
        wait_beats(10);
        sb_write(BASE, 32'h0005_BEEF);
        check("err_set", {31'b0, write_err}, 32'd1);
        wait_idle();
        commit();
        wait_idle();
        check("tap5_kept", {16'b0, got[5]}, 32'h1005);
        check("err_sticky", {31'b0, write_err}, 32'd1);
        do_clear();
        check("err_cleared", {31'b0, write_err}, 32'd0);
        sb_write(BASE, 32'h0005_BEEF);
        commit();
        wait_idle();
        check("tap5_new", {16'b0, got[5]}, 32'hBEEF);

        // Upper index bits ignored; unmapped address ignored.
        sb_write(BASE, 32'h00FF_1234);
        sb_write(BASE + 8'd2, 32'h0000_5555);
        commit();
        wait_idle();
        check("tap127_masked", {16'b0, got[127]}, 32'h1234);
        check("tap0_untouched", {16'b0, got[0]}, 32'h1000);

        // Reset mid-packet abandons it.
        commit();
        wait_beats(61);
        do_reset();
        @(negedge clk);
        check("rst_mid_tvalid", {31'b0, taps_tvalid}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_count", {16'b0, commit_count}, 32'd0);
        @(posedge clk);
        #1;
        commit();
        wait_idle();
        check("post_rst_beats", got_n, 32'd128);
        check("post_rst_tap0", {16'b0, got[0]}, 32'h1000);
        check("post_rst_tap5", {16'b0, got[5]}, 32'hBEEF);
        check("post_rst_count", {16'b0, commit_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/predistort_taps_loader.md
Name: predistort_taps_loader

Overview:
Sequences coefficient loading for the predistort block. Host software writes taps one at a time over the settings bus into a local table. A commit command streams the whole table as one AXI-Stream packet on the predistort taps port (taps_tdata/tlast/tvalid/tready). Sits beside predistort in the same clock domain, between the settings bus decoder and predistort.

Parameters:
WIDTH, 16, tap width in bits (matches predistort WIDTH)
DEPTH, 7, log2 of tap count; table holds 2^DEPTH taps (matches predistort DEPTH)
SR_BASE, 0, settings register base address (8-bit)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous soft clear
set_stb  in  1  settings write strobe
set_addr  in  8  settings address
set_data  in  32  settings data
taps_tdata  out  WIDTH  tap value to predistort
taps_tlast  out  1  high on final tap (index 2^DEPTH-1)
taps_tvalid  out  1  tap beat valid
taps_tready  in  1  predistort accepts beat
busy  out  1  packet in flight or commit pending
write_err  out  1  sticky: a tap write was dropped
commit_count  out  16  number of completed packets, wraps at 0xFFFF->0

Behaviour:
- Reset: taps_tvalid=0, taps_tlast=0, taps_tdata=0, busy=0, write_err=0, commit_count=0, FSM=IDLE, pending=0. Table contents are not reset.
- Register map:
  - SR_BASE+0 writes a tap: index=set_data[16+DEPTH-1:16], value=set_data[WIDTH-1:0]. Upper index bits are ignored.
  - SR_BASE+1 is commit; data is ignored. Other addresses are ignored.
- Tap write in IDLE: the table updates at the next clk edge.
- Tap write while busy=1: the write is dropped, the table is unchanged, and write_err sets.
- FSM states:
  - IDLE: on commit, issue the RAM read of index 0 and go to PRIME.
  - PRIME: load the output register with tap 0, assert taps_tvalid, issue the read of index 1, go to STREAM.
  - STREAM: on a handshake (tvalid & tready), present the next tap. The prefetch/skid register keeps throughput at 1 beat/cycle under continuous tready. On the handshake of index 2^DEPTH-1, increment commit_count. Then go to IDLE, or to PRIME if pending=1 (pending clears).
- Latency: commit strobe on cycle N gives first taps_tvalid on cycle N+2.
- With tready held high, the packet takes exactly 2^DEPTH consecutive cycles.
- AXI rules:
  - Once tvalid is asserted, tdata/tlast are held stable until the handshake.
  - tvalid never drops mid-packet except on reset.
  - tlast is asserted only on the last tap.
- Commit while not IDLE sets pending. Repeated commits collapse to one.
- Commit and tap write in the same cycle is impossible (single settings bus).
- busy = (state!=IDLE) | pending. It goes high the cycle after the commit strobe.
- clear:
  - Cancels pending and clears write_err.
  - A packet already in flight completes normally.
  - Does not touch the table or commit_count.
- reset mid-packet: tvalid=0 on the next cycle and the packet is abandoned. predistort shares the reset, so it is reset as well.
- write_err clears only on clear or reset.

Decomposition:
- Shared package:
  - SR offsets (SR_TAP=0, SR_COMMIT=1)
  - FSM state encoding (IDLE, PRIME, STREAM)
  - tap count constant 2^DEPTH
- One sub-module: taps_ram_1r1w. Simple dual-port RAM, one write port, one synchronous read port, 1-cycle read latency, no reset.
- The FSM, prefetch/skid register and counters live in the top.

Test Plan:
- Write index i, value 16'h1000+i for i=0..127; commit at cycle N; tready=1 -> tvalid first at N+2; 128 consecutive beats 0x1000..0x107F; tlast only on 0x107F; commit_count=1; busy low after the last beat.
- Same table; tready toggled pseudo-randomly (~50%) -> identical 128-value sequence, no drops or duplicates, tdata/tlast stable while tvalid&!tready.
- Commit issued 3 times during beat 40 of a packet -> exactly one further packet starts immediately after tlast; commit_count=2; busy stays high throughout.
- Tap write index 5 value 0xBEEF during streaming -> write_err=1; the next packet still carries tap 5 = 0x1005. After clear: write_err=0, a new write of 0xBEEF is accepted, and the next packet carries 0xBEEF at beat 6.
- Write with set_data=32'h00FF_1234 (index bits 0x7F plus ignored bits) -> tap 127 = 0x1234. A write to SR_BASE+2 changes nothing.
- Assert reset at beat 60 -> tvalid=0 next cycle; busy=0, commit_count=0. A fresh commit gives a full 128-beat packet starting at tap 0.
